// File: rtl/ip_boot_ram_if.sv
// CPU bus and loader stream of the boot RAM, bundled so both sides share one port list.
// The master drives requests and loader bytes; the slave (the RAM) returns data and status.
interface ip_boot_ram_if #(
   parameter int ADDR_W = 14
);
   logic              n_cs;
   logic              n_rd;
   logic              n_wr;
   logic [ADDR_W-1:0] address;
   logic [7:0]        wdata;
   logic [7:0]        rdata;
   logic              rdata_en;
   logic              load_valid;
   logic [7:0]        load_data;
   logic              load_last;
   logic              load_ready;
   logic              reload;
   logic              busy;

   modport master (
      output n_cs, n_rd, n_wr, address, wdata,
      output load_valid, load_data, load_last, reload,
      input  rdata, rdata_en, load_ready, busy
   );

   modport slave (
      input  n_cs, n_rd, n_wr, address, wdata,
      input  load_valid, load_data, load_last, reload,
      output rdata, rdata_en, load_ready, busy
   );
endinterface

// File: rtl/ip_boot_ram.sv
// Byte-wide program RAM: filled from a loader stream after reset, then serves pipelined
// CPU reads (and optional writes). Read data is forced to zero when not valid for bus OR-ing.
module ip_boot_ram #(
   parameter int ADDR_W       = 14,
   parameter int DEPTH        = 16384,
   parameter int READ_LATENCY = 1,
   parameter int WRITABLE     = 0
) (
   input  logic         clk,
   input  logic         reset,
   ip_boot_ram_if.slave bus
);
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IX = IDX_W'(DEPTH - 1);
   localparam bit                CPU_WR  = (WRITABLE != 0);

   typedef enum logic {LOAD, RUN} state_t;

   state_t            state_reg;
   logic [IDX_W-1:0]  ptr_reg;
   logic              busy_reg;
   logic              load_ready_reg;

   logic [7:0]        mem [DEPTH];

   logic [READ_LATENCY-1:0] vld_pipe;
   logic [READ_LATENCY-1:0] oob_pipe;
   logic [7:0]              dat_pipe [READ_LATENCY];

   logic              in_range;
   logic [IDX_W-1:0]  cpu_idx;
   logic              rd_req;
   logic              wr_req;
   logic              load_acc;
   logic              load_done;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [7:0]        mem_wdata;

   assign in_range  = ({1'b0, bus.address} < DEPTH_W);
   assign cpu_idx   = bus.address[IDX_W-1:0];
   assign rd_req    = (state_reg == RUN) && !bus.n_cs && !bus.n_rd;
   assign wr_req    = (state_reg == RUN) && !bus.n_cs && !bus.n_wr;
   assign load_acc  = (state_reg == LOAD) && bus.load_valid && load_ready_reg;
   assign load_done = load_acc && (bus.load_last || (ptr_reg == LAST_IX));

   // One write port shared by the loader (LOAD) and the CPU (RUN); reset suppresses both.
   assign mem_we    = !reset && (load_acc || (CPU_WR && wr_req && in_range));
   assign mem_waddr = (state_reg == LOAD) ? ptr_reg : cpu_idx;
   assign mem_wdata = (state_reg == LOAD) ? bus.load_data : bus.wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= LOAD;
         ptr_reg        <= '0;
         busy_reg       <= 1'b1;
         load_ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            LOAD: begin
               if (load_acc) begin
                  ptr_reg <= ptr_reg + 1'b1;
               end
               if (load_done) begin
                  state_reg      <= RUN;
                  busy_reg       <= 1'b0;
                  load_ready_reg <= 1'b0;
               end
            end
            RUN: begin
               if (bus.reload) begin
                  state_reg      <= LOAD;
                  ptr_reg        <= '0;
                  busy_reg       <= 1'b1;
                  load_ready_reg <= 1'b1;
               end
            end
            default: state_reg <= LOAD;
         endcase
      end
   end

   // Read-first RAM: a read on the same edge as a write to that byte returns the old value.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      if (rd_req) begin
         dat_pipe[0] <= mem[cpu_idx];
      end
      oob_pipe[0] <= !in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
         dat_pipe[i] <= dat_pipe[i-1];
         oob_pipe[i] <= oob_pipe[i-1];
      end
   end

   // Only the valid flags need reset; in-flight reads survive a reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_req;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   assign bus.rdata_en   = vld_pipe[READ_LATENCY-1];
   assign bus.rdata      = (vld_pipe[READ_LATENCY-1] && !oob_pipe[READ_LATENCY-1])
                           ? dat_pipe[READ_LATENCY-1] : 8'h00;
   assign bus.busy       = busy_reg;
   assign bus.load_ready = load_ready_reg;
endmodule

// File: tb/tb_ip_boot_ram.sv
// Two boot RAMs (latency 1 writable, latency 3 ROM, both 8 bytes deep) driven in lockstep;
// each read pushes its expected byte and arrival cycle, and per-instance monitors pop on rdata_en.
module tb_ip_boot_ram;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       n_cs = 1'b1, n_rd = 1'b1, n_wr = 1'b1;
   logic [3:0] address = '0;
   logic [7:0] wdata = '0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = '0;
   logic       load_last = 1'b0;
   logic       reload = 1'b0;

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   exp_t qa[$];
   exp_t qb[$];

   ip_boot_ram_if #(.ADDR_W(4)) ifa();
   ip_boot_ram_if #(.ADDR_W(4)) ifb();

   assign ifa.n_cs = n_cs;             assign ifb.n_cs = n_cs;
   assign ifa.n_rd = n_rd;             assign ifb.n_rd = n_rd;
   assign ifa.n_wr = n_wr;             assign ifb.n_wr = n_wr;
   assign ifa.address = address;       assign ifb.address = address;
   assign ifa.wdata = wdata;           assign ifb.wdata = wdata;
   assign ifa.load_valid = load_valid; assign ifb.load_valid = load_valid;
   assign ifa.load_data = load_data;   assign ifb.load_data = load_data;
   assign ifa.load_last = load_last;   assign ifb.load_last = load_last;
   assign ifa.reload = reload;         assign ifb.reload = reload;

   ip_boot_ram #(.ADDR_W(4), .DEPTH(8), .READ_LATENCY(LAT_A), .WRITABLE(1)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );
   ip_boot_ram #(.ADDR_W(4), .DEPTH(8), .READ_LATENCY(LAT_B), .WRITABLE(0)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bus cycle: inputs set after the falling edge, sampled on the next rising edge.
   task automatic step(input bit rd, input bit wr, input logic [3:0] a, input logic [7:0] wd,
                       input bit lv, input logic [7:0] ld, input bit ll, input bit rl);
      @(negedge clk);
      n_cs = !(rd || wr); n_rd = !rd; n_wr = !wr; address = a; wdata = wd;
      load_valid = lv; load_data = ld; load_last = ll; reload = rl;
   endtask

   task automatic idle();
      step(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0);
   endtask

   task automatic cpu(input bit rd, input bit wr, input logic [3:0] a, input logic [7:0] wd,
                      input logic [7:0] ea, input logic [7:0] eb, input bit rl);
      step(rd, wr, a, wd, 0, 8'h00, 0, rl);
      if (rd) begin
         qa.push_back('{ea, cyc + LAT_A});
         qb.push_back('{eb, cyc + LAT_B});
      end
   endtask

   task automatic status(input string name, input bit busy_exp, input bit rdy_exp);
      chk({name, "_busy_a"}, {7'b0, ifa.busy}, {7'b0, busy_exp});
      chk({name, "_busy_b"}, {7'b0, ifb.busy}, {7'b0, busy_exp});
      chk({name, "_ready_a"}, {7'b0, ifa.load_ready}, {7'b0, rdy_exp});
      chk({name, "_ready_b"}, {7'b0, ifb.load_ready}, {7'b0, rdy_exp});
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (ifa.rdata_en === 1'b1) begin
         checks++;
         if (qa.size() == 0) begin
            fails++;
            $display("FAIL rd_a: unexpected rdata_en data %h at cycle %0d", ifa.rdata, cyc);
         end else begin
            e = qa.pop_front();
            if (ifa.rdata !== e.d || cyc != e.c) begin
               fails++;
               $display("FAIL rd_a: data %h at cycle %0d, expected %h at cycle %0d",
                        ifa.rdata, cyc, e.d, e.c);
            end
         end
      end else if (ifa.rdata !== 8'h00 || ifa.rdata_en !== 1'b0) begin
         checks++;
         fails++;
         $display("FAIL idle_a: rdata %h en %b, expected 00 en 0 at cycle %0d",
                  ifa.rdata, ifa.rdata_en, cyc);
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (ifb.rdata_en === 1'b1) begin
         checks++;
         if (qb.size() == 0) begin
            fails++;
            $display("FAIL rd_b: unexpected rdata_en data %h at cycle %0d", ifb.rdata, cyc);
         end else begin
            e = qb.pop_front();
            if (ifb.rdata !== e.d || cyc != e.c) begin
               fails++;
               $display("FAIL rd_b: data %h at cycle %0d, expected %h at cycle %0d",
                        ifb.rdata, cyc, e.d, e.c);
            end
         end
      end else if (ifb.rdata !== 8'h00 || ifb.rdata_en !== 1'b0) begin
         checks++;
         fails++;
         $display("FAIL idle_b: rdata %h en %b, expected 00 en 0 at cycle %0d",
                  ifb.rdata, ifb.rdata_en, cyc);
      end
   end

   initial begin
      logic [7:0] img [5];
      logic [7:0] abcd [4];
      img  = '{8'hF3, 8'h31, 8'h00, 8'h00, 8'h80};
      abcd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

      repeat (2) idle();
      reset = 1'b0;
      status("reset", 1, 1);

      // CPU traffic during LOAD is ignored: no read data, no write of 77 into addr 3
      step(1, 1, 4'h3, 8'h77, 0, 8'h00, 0, 0);
      idle();
      status("load_cpu", 1, 1);

      // Image F3,31,<stall>,00,80 with last on the final byte
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 4'h0, 8'h00, (i != 2), img[i], (i == 4), 0);
         status($sformatf("stream%0d", i), 1, 1);
      end
      idle();
      status("loaded", 0, 0);

      for (int i = 0; i < 4; i++) begin
         cpu(1, 0, 4'(i), 8'h00, img[(i < 2) ? i : i + 1], img[(i < 2) ? i : i + 1], 0);
         idle();
      end

      // Back-to-back reads, out-of-range reads
      cpu(1, 0, 4'h1, 8'h00, 8'h31, 8'h31, 0);
      cpu(1, 0, 4'h2, 8'h00, 8'h00, 8'h00, 0);
      cpu(1, 0, 4'h3, 8'h00, 8'h80, 8'h80, 0);
      cpu(1, 0, 4'h8, 8'h00, 8'h00, 8'h00, 0);
      cpu(1, 0, 4'hF, 8'h00, 8'h00, 8'h00, 0);
      idle();

      // Read-during-write returns old byte; next read sees new byte only when writable
      cpu(1, 1, 4'h2, 8'h5A, 8'h00, 8'h00, 0);
      cpu(1, 0, 4'h2, 8'h00, 8'h5A, 8'h00, 0);
      // Out-of-range write must not alias onto addr 1
      cpu(0, 1, 4'h9, 8'h11, 8'h00, 8'h00, 0);
      cpu(1, 0, 4'h1, 8'h00, 8'h31, 8'h31, 0);
      idle();

      // Reload on the same edge as a read: the read still completes
      cpu(1, 0, 4'h0, 8'h00, 8'hF3, 8'hF3, 1);
      idle();
      status("reloaded", 1, 1);
      step(1, 1, 4'h3, 8'h77, 0, 8'h00, 0, 0);

      // Partial load interrupted by reset, then a 2-byte image
      step(0, 0, 4'h0, 8'h00, 1, 8'hAA, 0, 0);
      step(0, 0, 4'h0, 8'h00, 1, 8'hBB, 0, 0);
      idle();
      reset = 1'b1;
      idle();
      reset = 1'b0;
      status("midreset", 1, 1);
      step(0, 0, 4'h0, 8'h00, 1, 8'hAA, 0, 0);
      step(0, 0, 4'h0, 8'h00, 1, 8'hBB, 1, 0);
      idle();
      status("short", 0, 0);
      cpu(1, 0, 4'h0, 8'h00, 8'hAA, 8'hAA, 0);
      cpu(1, 0, 4'h1, 8'h00, 8'hBB, 8'hBB, 0);
      cpu(1, 0, 4'h2, 8'h00, 8'h5A, 8'h00, 0);
      cpu(1, 0, 4'h3, 8'h00, 8'h80, 8'h80, 0);

      // Full 4-byte reload AA..DD
      cpu(0, 0, 4'h0, 8'h00, 8'h00, 8'h00, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 8'h00, 1, abcd[i], (i == 3), 0);
      idle();
      for (int i = 0; i < 4; i++) cpu(1, 0, 4'(i), 8'h00, abcd[i], abcd[i], 0);
      idle();

      // Overflow: 10 bytes, no last; reload pulse mid-stream is ignored in LOAD
      cpu(0, 0, 4'h0, 8'h00, 8'h00, 8'h00, 1);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 4'h0, 8'h00, 1, 8'(8'h10 + i), 0, (i == 3));
         status($sformatf("fill%0d", i), (i < 8), (i < 8));
      end
      idle();
      status("full", 0, 0);
      for (int i = 0; i < 9; i++) begin
         cpu(1, 0, 4'(i), 8'h00, (i < 8) ? 8'(8'h10 + i) : 8'h00,
             (i < 8) ? 8'(8'h10 + i) : 8'h00, 0);
      end

      repeat (8) idle();
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d/%0d reads outstanding, expected 0/0", qa.size(), qb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
